// File: rtl/duty_ramp_pkg.sv
// Shared types/constants for the duty slew limiter; HOLD state only when DUTY_RAMP_HOLD_EN is defined.
// Pure declarations: no latency, no flow control.
package duty_ramp_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd100;

`ifdef DUTY_RAMP_HOLD_EN
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;
`endif

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Ramp tick divider: one-cycle tick every DIV enabled cycles, counter held at 0 while disabled.
// clr restarts the count at 0 on the next edge; no backpressure.
module tick_prescaler #(
    parameter int DIV = 100000
) (
    input  logic fclk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge fclk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/duty_ramp.sv
// Slew-rate limiter for the PWM duty: steps duty toward an accepted target every STEP_DIV cycles; optional auto-off via DUTY_RAMP_HOLD_EN.
// Registered outputs; tgt_ready is low for the whole ramp, so new targets wait until the current one is reached.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int STEP_DIV   = 100000,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 5000
) (
    input  logic       fclk,
    input  logic       reset,
    input  logic [7:0] tgt_duty,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    output logic [7:0] duty,
    output logic       busy,
    output logic       at_target,
    output logic       err_range
);

    localparam logic [DUTY_W:0]   STEP9 = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] STEP8 = DUTY_W'(STEP);

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic              err_q, err_d;
    logic              accept, tick, hold_st;
    logic [DUTY_W-1:0] tgt_in;
    logic [DUTY_W:0]   up9, dn_lim9;
    state_t            settle_in, settle_cur;

    assign accept = tgt_valid & tgt_ready;
    assign tgt_in = clamp_duty(tgt_duty);
    // 9-bit arithmetic so the step can never wrap past 255 or below 0
    assign up9     = {1'b0, duty_q} + STEP9;
    assign dn_lim9 = {1'b0, tgt_q} + STEP9;

`ifdef DUTY_RAMP_HOLD_EN
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    logic [HW-1:0] hold_q, hold_d;

    assign hold_st    = (state_q == HOLD);
    assign settle_in  = (tgt_in != '0) ? HOLD : IDLE;
    assign settle_cur = (tgt_q != '0) ? HOLD : IDLE;
`else
    assign hold_st    = 1'b0;
    assign settle_in  = IDLE;
    assign settle_cur = IDLE;
`endif

    tick_prescaler #(.DIV(STEP_DIV)) u_presc (
        .fclk  (fclk),
        .reset (reset),
        .clr   (accept),
        .en    (busy | hold_st),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        err_d   = 1'b0;
`ifdef DUTY_RAMP_HOLD_EN
        hold_d  = '0;
`endif
        if (accept) begin
            tgt_d = tgt_in;
            err_d = (tgt_duty > DUTY_MAX);
            if (tgt_in > duty_q) begin
                state_d = RAMP_UP;
            end else if (tgt_in < duty_q) begin
                state_d = RAMP_DOWN;
            end else begin
                state_d = settle_in;
            end
        end else begin
            case (state_q)
                RAMP_UP: begin
                    if (tick) begin
                        if (up9 >= {1'b0, tgt_q}) begin
                            duty_d  = tgt_q;
                            state_d = settle_cur;
                        end else begin
                            duty_d = up9[DUTY_W-1:0];
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (tick) begin
                        if ({1'b0, duty_q} <= dn_lim9) begin
                            duty_d  = tgt_q;
                            state_d = settle_cur;
                        end else begin
                            duty_d = duty_q - STEP8;
                        end
                    end
                end
`ifdef DUTY_RAMP_HOLD_EN
                HOLD: begin
                    hold_d = hold_q;
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            tgt_d   = '0;
                            state_d = RAMP_DOWN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (!reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
`ifdef DUTY_RAMP_HOLD_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
`ifdef DUTY_RAMP_HOLD_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign busy      = (state_q == RAMP_UP) | (state_q == RAMP_DOWN);
    assign tgt_ready = (state_q == IDLE) | hold_st;
    assign duty      = duty_q;
    assign at_target = (duty_q == tgt_q) & ~busy;
    assign err_range = err_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp (STEP_DIV=4, STEP=10, HOLD_TICKS=2): expected duty steps queued with their edge numbers, checked by a monitor.
module tb_duty_ramp;

    logic       fclk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tgt_duty = 8'd0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready, busy, at_target, err_range;
    logic [7:0] duty;

    typedef struct {
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev_duty;

    duty_ramp #(.STEP_DIV(4), .STEP(10), .HOLD_TICKS(2)) dut (
        .fclk      (fclk),
        .reset     (reset),
        .tgt_duty  (tgt_duty),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .duty      (duty),
        .busy      (busy),
        .at_target (at_target),
        .err_range (err_range)
    );

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    // every duty change must match the next queued value at the queued edge
    always @(negedge fclk) begin
        if (mon_en && duty !== prev_duty) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL duty_unexpected: got %0d at edge %0d, none expected", duty, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (duty !== e.d || cyc != e.at) begin
                    fails++;
                    $display("FAIL duty_step: got %0d at edge %0d, expected %0d at edge %0d",
                             duty, cyc, e.d, e.at);
                end
            end
            prev_duty = duty;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic push(input int d, input int at);
        exp_t e;
        e.d  = d[7:0];
        e.at = at;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge fclk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tgt_ready && n < 200) begin
            @(negedge fclk);
            n++;
        end
        if (!tgt_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: tgt_ready %0b after %0d cycles, expected 1", tgt_ready, n);
        end
    endtask

    // drives one target at a negedge; returns the edge number at which it is accepted
    task automatic accept(input int v, output int ac);
        wait_ready();
        tgt_duty  = v[7:0];
        tgt_valid = 1'b1;
        ac = cyc + 1;
        @(negedge fclk);
        tgt_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ac, ac2;

        // 1: reset state and quiet idle
        repeat (3) @(negedge fclk);
        check("reset_state", {duty, tgt_ready, at_target, busy, err_range}, {8'd0, 4'b1100});
        reset     = 1'b1;
        prev_duty = 8'd0;
        mon_en    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge fclk);
            check("idle_state", {duty, tgt_ready, at_target, busy, err_range}, {8'd0, 4'b1100});
        end

`ifdef DUTY_RAMP_HOLD_EN
        // 6a: reach 20, hold two ticks (8 cycles), auto-off ramp to 0
        accept(20, ac);
        push(10, ac + 4);
        push(20, ac + 8);
        push(10, ac + 20);
        push(0, ac + 24);
        wait_cyc(ac + 10);
        check("hold_flags", {tgt_ready, at_target, busy}, 3'b110);
        wait_cyc(ac + 15);
        check("hold_not_busy", busy, 1'b0);
        wait_cyc(ac + 16);
        check("autooff_busy", busy, 1'b1);
        wait_cyc(ac + 24);
        check("autooff_done", {tgt_ready, at_target, busy}, 3'b110);

        // 6b: new target 40 during HOLD cancels the countdown
        accept(20, ac);
        push(10, ac + 4);
        push(20, ac + 8);
        wait_cyc(ac + 10);
        accept(40, ac2);
        check("hold_accept_edge", ac2, ac + 11);
        push(30, ac2 + 4);
        push(40, ac2 + 8);
        push(30, ac2 + 20);
        push(20, ac2 + 24);
        push(10, ac2 + 28);
        push(0, ac2 + 32);
        wait_cyc(ac2 + 12);
        check("hold40_ready", tgt_ready, 1'b1);
        wait_cyc(ac2 + 32);
        check("hold40_done", {tgt_ready, at_target, busy}, 3'b110);
`else
        // 2: ramp up 0 -> 35
        accept(35, ac);
        push(10, ac + 4);
        push(20, ac + 8);
        push(30, ac + 12);
        push(35, ac + 16);
        check("up_busy_rise", {busy, tgt_ready}, 2'b10);
        wait_cyc(ac + 15);
        check("up_busy_last", {busy, tgt_ready}, 2'b10);
        wait_cyc(ac + 16);
        check("up_done", {busy, tgt_ready, at_target}, 3'b011);

        // 3: ramp down 35 -> 3, last step clamps
        accept(3, ac);
        push(25, ac + 4);
        push(15, ac + 8);
        push(5, ac + 12);
        push(3, ac + 16);
        wait_cyc(ac + 16);
        check("down_done", {duty, at_target}, {8'd3, 1'b1});

        // 4: out-of-range target clamps to 100
        accept(200, ac);
        check("err_pulse", err_range, 1'b1);
        @(negedge fclk);
        check("err_clear", err_range, 1'b0);
        for (int k = 1; k <= 9; k++) push(3 + 10 * k, ac + 4 * k);
        push(100, ac + 40);
        wait_cyc(ac + 40);
        check("clamp_done", {duty, tgt_ready, at_target}, {8'd100, 2'b11});

        // 5a: request during a ramp waits for tgt_ready
        accept(60, ac);
        push(90, ac + 4);
        push(80, ac + 8);
        push(70, ac + 12);
        push(60, ac + 16);
        wait_cyc(ac + 2);
        tgt_duty  = 8'd50;
        tgt_valid = 1'b1;
        check("ramp_not_ready", tgt_ready, 1'b0);
        wait_cyc(ac + 15);
        check("ramp_still_not_ready", tgt_ready, 1'b0);
        wait_cyc(ac + 17);
        tgt_valid = 1'b0;
        check("held_req_accepted", busy, 1'b1);
        push(50, ac + 21);
        wait_cyc(ac + 21);

        // 5b: reset mid-ramp drops duty to 0 at once
        accept(100, ac);
        push(60, ac + 4);
        push(70, ac + 8);
        wait_cyc(ac + 9);
        reset = 1'b0;
        push(0, ac + 10);
        @(negedge fclk);
        reset = 1'b1;
        check("mid_reset", {duty, tgt_ready, at_target, busy}, {8'd0, 3'b110});
`endif

        repeat (10) @(negedge fclk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
